led_pattern_engine: RTL and testbench
=====================================

LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 Parameter N_LEDS, 8, LED count; SHALL be even, range 4..16.
REQ-002 Parameter FAST_DIV, 625000, clk cycles per frame step when speed_sel=0; SHALL be >=2.
REQ-003 Parameter SLOW_DIV, 2500000, clk cycles per frame step when speed_sel=1; SHALL be >=2.
REQ-004 clk  in  1  system clock; single clock domain, no derived clocks.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ena  in  1  enable; low freezes all state.
REQ-007 pat_sel  in  3  pattern request.
REQ-008 speed_sel  in  1  0=FAST_DIV, 1=SLOW_DIV.
REQ-009 pause  in  1  holds divider and frame state.
REQ-010 step  in  1  single-cycle strobe; while paused, forces one frame advance.
REQ-011 led_out  out  N_LEDS  LED drive, registered.
REQ-012 frame_tick  out  1  one-cycle pulse on every frame advance.
REQ-013 pat_cur  out  3  active pattern code.

Function
REQ-014 Divider SHALL count 0..DIV-1 while ena=1 and pause=0; at DIV-1 it SHALL wrap to 0 and raise an internal tick for one cycle.
REQ-015 Any change of speed_sel SHALL clear the divider to 0 without a tick in that cycle.
REQ-016 Frame advance SHALL occur on tick, or on step=1 while pause=1 and ena=1; step while pause=0 SHALL be ignored.
REQ-017 led_out SHALL update only in the advance cycle, and frame_tick SHALL be high in exactly that cycle; the update is visible one clk later.
REQ-018 With ena=1 and pat_sel!=pat_cur, pat_cur SHALL load pat_sel and clear pos, dir and toggle to 0; led_out SHALL hold until the next advance.
REQ-019 If a pattern change and an advance coincide, the change SHALL win and the advance SHALL be dropped.
REQ-020 Toggle SHALL invert on every advance; patterns 3 and 4 SHALL use the post-invert value.
REQ-021 H = N_LEDS/2.
- Pattern 0 (mirror pair): led_out = bit(pos) | bit(N_LEDS-1-pos).
- pos SHALL bounce 0..H-1..0, with no repeated frame at either end.
REQ-022 Pattern 1 (walking pair): led_out = bits pos and pos+1.
- pos SHALL bounce 0..N_LEDS-2..0, with no repeated frame at either end.
REQ-023 Pattern 2 (expand/contract): level L SHALL cycle 0..2H-1.
- Radius r = L for L<H, else 2H-2-L.
- Lit bits are H-1-r..H+r; L=2H-1 SHALL be all off.
- For N_LEDS=8: 18,3C,7E,FF,7E,3C,18,00.
REQ-024 Pattern 3: toggle=1 all on, else all off.
REQ-025 Pattern 4: toggle=1 alternating with MSB set (AA for 8), else the complement (55).
REQ-026 Pattern 5 (marquee): led_out SHALL take the register value before rotation.
- Register resets to 3 LSBs set and rotates left by 1 per advance.
REQ-027 Pattern 6 (sparkle): 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
- led_out SHALL take lfsr[N_LEDS-1:0] before the shift.
- The LFSR SHALL NOT reset on pattern change and SHALL never reach zero.
REQ-028 Pattern 7: led_out SHALL be all 0.
REQ-029 ena=0 SHALL freeze the divider, pat_cur, frame state and led_out; step and pat_sel SHALL be ignored.

Reset
REQ-030 Reset values: led_out=0, frame_tick=0, pat_cur=7, divider=0, pos=0, dir=0, toggle=0, L=0, marquee=3 LSBs set, lfsr=ACE1.
REQ-031 Reset mid-frame SHALL take effect immediately; the first advance after release SHALL produce the first frame of pat_cur.

Structure
REQ-032 Shared package led_pkg SHALL hold the pattern code constants (PAT_MIRROR..PAT_OFF), LFSR_SEED and the LFSR tap mask.
REQ-033 Sub-module led_tick_gen SHALL contain the divider, speed-change clear and pause/step qualification; it SHALL output a one-cycle advance strobe.

Verification (bench uses FAST_DIV=4, SLOW_DIV=8, N_LEDS=8)
REQ-034 pat_sel=0, ena=1 -> led_out steps 81,42,24,18,24,42,81,42 on successive frame_ticks, 4 clks apart.
REQ-035 pat_sel=2 -> 18,3C,7E,FF,7E,3C,18,00,18; switch speed_sel=1 mid-count -> next tick 8 clks after switch.
REQ-036 pat_sel=1, pause=1 for 40 clks -> no frame_tick; three step pulses -> exactly 3 advances: 03,06,0C.
REQ-037 pat_sel=6 -> first frame E1; 65535 consecutive frames non-zero-state, period exactly 65535.
REQ-038 pat_sel 5->3 at tick cycle -> no advance that cycle, then FF,00,FF; ena=0 for 20 clks -> led_out and divider frozen.
REQ-039 rst_n low mid-pattern-0 -> led_out=00, pat_cur=7 immediately; after release, pattern 7 frames are 00.

Source files
------------

// File: rtl/led_pkg.sv
// Shared pattern codes and LFSR constants for the LED pattern engine.
package led_pkg;

    typedef enum logic [2:0] {
        PAT_MIRROR  = 3'd0,
        PAT_WALK    = 3'd1,
        PAT_EXPAND  = 3'd2,
        PAT_FLASH   = 3'd3,
        PAT_ALT     = 3'd4,
        PAT_MARQUEE = 3'd5,
        PAT_SPARKLE = 3'd6,
        PAT_OFF     = 3'd7
    } pat_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Frame-rate divider with speed-change clear and pause/step qualification.
module led_tick_gen #(
    parameter int FAST_DIV = 625000,
    parameter int SLOW_DIV = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic speed_sel,
    input  logic pause,
    input  logic step,
    output logic advance
);

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int DIV_W   = $clog2(MAX_DIV);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             spd_q;
    logic             spd_chg;
    logic             tick;
    logic [DIV_W-1:0] div_last;

    assign div_last = spd_q ? SLOW_LAST : FAST_LAST;
    // A speed switch restarts the count and suppresses any tick in that cycle.
    assign spd_chg  = ena && (speed_sel != spd_q);
    assign tick     = ena && !pause && !spd_chg && (div_q == div_last);
    assign advance  = rst_n && ena && (tick || (pause && step));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            spd_q <= 1'b0;
        end else if (ena) begin
            spd_q <= speed_sel;
            if (spd_chg)
                div_q <= '0;
            else if (!pause)
                div_q <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: eight selectable frame patterns advanced by a divided
// frame tick or by single steps while paused.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int FAST_DIV = 625000,
    parameter int SLOW_DIV = 2500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [2:0]        pat_sel,
    input  logic              speed_sel,
    input  logic              pause,
    input  logic              step,
    output logic [N_LEDS-1:0] led_out,
    output logic              frame_tick,
    output logic [2:0]        pat_cur
);

    localparam int H     = N_LEDS / 2;
    localparam int POS_W = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] LVL_LAST = POS_W'(2 * H - 1);

    pat_e              pat_q;
    logic [POS_W-1:0]  pos_q;
    logic              dir_q;
    logic              tog_q;
    logic [N_LEDS-1:0] mq_q;
    logic [N_LEDS-1:0] led_q;
    logic [15:0]       lfsr_q;

    logic              advance;
    logic              pat_chg;
    logic              adv_ok;
    logic              tog_nxt;
    logic [POS_W-1:0]  pos_max;
    logic [POS_W-1:0]  pos_bnc;
    logic              dir_bnc;
    logic [POS_W-1:0]  mir_idx;
    logic [N_LEDS-1:0] frame;
    int                lvl;
    int                rad;

    led_tick_gen #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .speed_sel (speed_sel),
        .pause     (pause),
        .step      (step),
        .advance   (advance)
    );

    // A pattern change takes priority and swallows a coincident advance.
    assign pat_chg = ena && (pat_e'(pat_sel) != pat_q);
    assign adv_ok  = advance && !pat_chg;
    assign tog_nxt = ~tog_q;

    // Bounce position for mirror/walk: turn around without repeating the end frame.
    always_comb begin
        pos_max = (pat_q == PAT_MIRROR) ? POS_W'(H - 1) : POS_W'(N_LEDS - 2);
        pos_bnc = pos_q;
        dir_bnc = dir_q;
        if (!dir_q) begin
            if (pos_q == pos_max) begin
                pos_bnc = pos_q - POS_W'(1);
                dir_bnc = 1'b1;
            end else begin
                pos_bnc = pos_q + POS_W'(1);
            end
        end else begin
            if (pos_q == '0) begin
                pos_bnc = pos_q + POS_W'(1);
                dir_bnc = 1'b0;
            end else begin
                pos_bnc = pos_q - POS_W'(1);
            end
        end
    end

    always_comb begin
        frame   = '0;
        lvl     = int'(pos_q);
        rad     = (lvl < H) ? lvl : 2 * H - 2 - lvl;
        mir_idx = POS_W'(N_LEDS - 1) - pos_q;
        case (pat_q)
            PAT_MIRROR: begin
                frame[pos_q]   = 1'b1;
                frame[mir_idx] = 1'b1;
            end
            PAT_WALK: begin
                frame[pos_q]              = 1'b1;
                frame[pos_q + POS_W'(1)]  = 1'b1;
            end
            // Last level of the cycle is the dark frame.
            PAT_EXPAND: begin
                for (int i = 0; i < N_LEDS; i++)
                    frame[i] = (pos_q != LVL_LAST) && (i >= H - 1 - rad) && (i <= H + rad);
            end
            PAT_FLASH:   frame = {N_LEDS{tog_nxt}};
            PAT_ALT: begin
                for (int i = 0; i < N_LEDS; i++)
                    frame[i] = ((i % 2) == 1) == tog_nxt;
            end
            PAT_MARQUEE: frame = mq_q;
            PAT_SPARKLE: frame = lfsr_q[N_LEDS-1:0];
            default:     frame = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= PAT_OFF;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            tog_q  <= 1'b0;
            mq_q   <= {{(N_LEDS-3){1'b0}}, 3'b111};
            lfsr_q <= LFSR_SEED;
            led_q  <= '0;
        end else if (pat_chg) begin
            pat_q <= pat_e'(pat_sel);
            pos_q <= '0;
            dir_q <= 1'b0;
            tog_q <= 1'b0;
        end else if (adv_ok) begin
            led_q <= frame;
            tog_q <= tog_nxt;
            case (pat_q)
                PAT_MIRROR, PAT_WALK: begin
                    pos_q <= pos_bnc;
                    dir_q <= dir_bnc;
                end
                PAT_EXPAND:  pos_q  <= (pos_q == LVL_LAST) ? '0 : pos_q + POS_W'(1);
                PAT_MARQUEE: mq_q   <= {mq_q[N_LEDS-2:0], mq_q[N_LEDS-1]};
                PAT_SPARKLE: lfsr_q <= lfsr_next(lfsr_q);
                default: ;
            endcase
        end
    end

    assign led_out    = led_q;
    assign frame_tick = adv_ok;
    assign pat_cur    = pat_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed frames and timings.
module tb_led_pattern_engine;

    localparam int N    = 8;
    localparam int H    = N / 2;
    localparam int FAST = 4;
    localparam int SLOW = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic [2:0]   pat_sel = 3'd7;
    logic         speed_sel = 1'b0;
    logic         pause = 1'b0;
    logic         step = 1'b0;
    logic [N-1:0] led_out;
    logic         frame_tick;
    logic [2:0]   pat_cur;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_ticks = 0;

    led_pattern_engine #(.N_LEDS(N), .FAST_DIV(FAST), .SLOW_DIV(SLOW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pat_sel    (pat_sel),
        .speed_sel  (speed_sel),
        .pause      (pause),
        .step       (step),
        .led_out    (led_out),
        .frame_tick (frame_tick),
        .pat_cur    (pat_cur)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_tick) n_ticks <= n_ticks + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level model: frames are a function of the advance count since the
    // last pattern change (m_k), the marquee step count and the LFSR state.
    int           m_cnt = 0;
    bit           m_spd = 1'b0;
    int           m_pat = 7;
    int           m_k = 0;
    int           m_mq = 0;
    logic [15:0]  m_lfsr = 16'hACE1;
    logic [N-1:0] m_led = '0;

    function automatic int tri_pos(input int k, input int mx);
        int t;
        t = k % (2 * mx);
        return (t <= mx) ? t : 2 * mx - t;
    endfunction

    function automatic bit m_adv();
        int last;
        last = (m_spd ? SLOW : FAST) - 1;
        return rst_n && ena && ((!pause && (speed_sel == m_spd) && (m_cnt == last)) || (pause && step));
    endfunction

    function automatic logic [N-1:0] m_frame();
        logic [N-1:0] f;
        int p, lv, r, s;
        f = '0;
        case (m_pat)
            0: begin p = tri_pos(m_k, H - 1); f[p] = 1'b1; f[N-1-p] = 1'b1; end
            1: begin p = tri_pos(m_k, N - 2); f[p] = 1'b1; f[p+1] = 1'b1; end
            2: begin
                lv = m_k % (2 * H);
                if (lv != 2 * H - 1) begin
                    r = (lv < H) ? lv : 2 * H - 2 - lv;
                    for (int i = H - 1 - r; i <= H + r; i++) f[i] = 1'b1;
                end
            end
            3: f = (m_k % 2 == 0) ? '1 : '0;
            4: for (int i = 0; i < N; i++) f[i] = ((i % 2) == 1) == (m_k % 2 == 0);
            5: begin s = m_mq % N; for (int i = 0; i < 3; i++) f[(i + s) % N] = 1'b1; end
            6: f = m_lfsr[N-1:0];
            default: f = '0;
        endcase
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_spd <= 1'b0; m_pat <= 7; m_k <= 0;
            m_mq <= 0; m_lfsr <= 16'hACE1; m_led <= '0;
        end else if (ena) begin
            m_spd <= speed_sel;
            if (speed_sel != m_spd)
                m_cnt <= 0;
            else if (!pause)
                m_cnt <= (m_cnt == (m_spd ? SLOW : FAST) - 1) ? 0 : m_cnt + 1;
            if (int'(pat_sel) != m_pat) begin
                m_pat <= int'(pat_sel);
                m_k   <= 0;
            end else if (m_adv()) begin
                m_led <= m_frame();
                m_k   <= m_k + 1;
                if (m_pat == 5) m_mq <= m_mq + 1;
                // x^16+x^14+x^13+x^11+1 shifting right: taps at 16-16,16-14,16-13,16-11
                if (m_pat == 6) m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            end
        end
    end

    always @(negedge clk) begin
        chk("frame_tick", 32'(frame_tick), 32'(m_adv() && !(ena && int'(pat_sel) != m_pat)));
        chk("led_out", 32'(led_out), 32'(m_led));
        chk("pat_cur", 32'(pat_cur), 32'(m_pat));
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; ena = 1'b0; pat_sel = 3'd7; speed_sel = 1'b0; pause = 1'b0; step = 1'b0;
        @(negedge clk);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_pat", 32'(pat_cur), 32'd7);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Wait for the next advance (bounded), then check the frame it produced.
    task automatic next_frame(input string nm, input logic [N-1:0] exp, output int tcyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 50);
        tcyc = cyc;
        if (!frame_tick) chk({nm, "_timeout"}, 32'(frame_tick), 32'd1);
        @(negedge clk);
        chk(nm, 32'(led_out), 32'(exp));
    endtask

    task automatic go();
        @(posedge clk); #1;
    endtask

    logic [N-1:0] s1_exp [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h81, 8'h42};
    logic [N-1:0] s2_exp [9] = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00, 8'h18};
    logic [N-1:0] s3_exp [3] = '{8'h03, 8'h06, 8'h0C};

    initial begin
        int t, tp, sw, tk, e;
        logic [N-1:0] hold;

        // Mirror pair, ticks 4 clocks apart
        do_reset();
        go(); ena = 1'b1; pat_sel = 3'd0;
        tp = 0;
        for (int i = 0; i < 8; i++) begin
            next_frame("mirror", s1_exp[i], t);
            if (i > 0) chk("mirror_period", 32'(t - tp), 32'd4);
            tp = t;
        end

        // Expand/contract, then speed switch mid-count
        do_reset();
        go(); ena = 1'b1; pat_sel = 3'd2;
        for (int i = 0; i < 9; i++) next_frame("expand", s2_exp[i], t);
        go(); speed_sel = 1'b1; sw = cyc;
        next_frame("expand_slow", 8'h3C, t);
        chk("speed_switch_delay", 32'(t - sw), 32'd8);

        // Walking pair paused, stepped three times
        do_reset();
        go(); ena = 1'b1; pat_sel = 3'd1; pause = 1'b1;
        go(); tk = n_ticks;
        repeat (40) go();
        chk("pause_no_tick", 32'(n_ticks - tk), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            @(negedge clk); chk("step_tick", 32'(frame_tick), 32'd1);
            go(); step = 1'b0;
            @(negedge clk); chk("walk_step", 32'(led_out), 32'(s3_exp[i]));
            go();
        end
        chk("step_count", 32'(n_ticks - tk), 32'd3);

        // Sparkle: full LFSR period via held step while paused
        do_reset();
        go(); ena = 1'b1; pat_sel = 3'd6; pause = 1'b1;
        go(); step = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("sparkle_first", 32'(led_out), 32'hE1);
        repeat (65535) @(negedge clk);
        chk("sparkle_period", 32'(led_out), 32'hE1);
        go(); step = 1'b0;

        // Marquee, change to flash on a tick cycle, then ena freeze
        do_reset();
        go(); ena = 1'b1; pat_sel = 3'd5;
        next_frame("marquee", 8'h07, t);
        next_frame("marquee", 8'h0E, t);
        repeat (3) go();
        pat_sel = 3'd3;
        @(negedge clk); chk("chg_drops_adv", 32'(frame_tick), 32'd0);
        @(negedge clk); chk("chg_holds_led", 32'(led_out), 32'h0E);
        next_frame("flash", 8'hFF, t);
        next_frame("flash", 8'h00, t);
        next_frame("flash", 8'hFF, t);
        go(); ena = 1'b0; hold = led_out; tk = n_ticks; pat_sel = 3'd4;
        repeat (10) go();
        pat_sel = 3'd3;
        repeat (10) go();
        chk("freeze_led", 32'(led_out), 32'(hold));
        chk("freeze_no_tick", 32'(n_ticks - tk), 32'd0);
        chk("freeze_pat", 32'(pat_cur), 32'd3);
        ena = 1'b1; e = cyc;
        next_frame("flash_resume", 8'h00, t);
        chk("freeze_divider", 32'(t - e), 32'd2);

        // Async reset mid-pattern, then pattern 7 frames
        do_reset();
        go(); ena = 1'b1; pat_sel = 3'd0;
        next_frame("mirror2", 8'h81, t);
        go(); step = 1'b1;
        @(negedge clk); chk("step_unpaused", 32'(frame_tick), 32'd0);
        go(); step = 1'b0;
        next_frame("mirror2", 8'h42, t);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_out), 32'h0);
        chk("async_rst_pat", 32'(pat_cur), 32'd7);
        pat_sel = 3'd7;
        repeat (2) go();
        rst_n = 1'b1;
        next_frame("off", 8'h00, t);
        next_frame("off", 8'h00, tp);
        chk("off_period", 32'(tp - t), 32'd4);

        repeat (3) go();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1500000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
